exu_alu_dpath_arb: RTL and testbench
====================================

Name: exu_alu_dpath_arb

Overview:
Sequencing arbiter in front of the shared EXU ALU datapath. It arbitrates between the ALU requester (add/lui) and the BJP requester (address add) with round-robin priority. It drives exactly one datapath request select per transaction, registers the datapath result, and returns it to the granted requester over a valid/ready response channel. It sits between the EXU dispatch/BJP logic and the combinational ALU datapath.

Parameters:
XLEN, 32, operand/result width
ALU_ADDER_WIDTH, XLEN+1, internal adder width; documentation only, not consumed here

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
alu_req_valid  in  1  ALU request valid
alu_req_ready  out  1  ALU request accepted
alu_req_add  in  1  ALU op: add
alu_req_lui  in  1  ALU op: move op2 (lui)
alu_req_op1  in  XLEN  ALU operand 1
alu_req_op2  in  XLEN  ALU operand 2
alu_rsp_valid  out  1  ALU result valid
alu_rsp_ready  in  1  ALU result taken
alu_rsp_res  out  XLEN  ALU result
bjp_req_valid  in  1  BJP request valid
bjp_req_ready  out  1  BJP request accepted
bjp_req_op1  in  XLEN  BJP operand 1
bjp_req_op2  in  XLEN  BJP operand 2
bjp_rsp_valid  out  1  BJP result valid
bjp_rsp_ready  in  1  BJP result taken
bjp_rsp_res  out  XLEN  BJP add result
dp_alu_req  out  1  datapath select: ALU requester
dp_alu_add  out  1  datapath ALU add
dp_alu_lui  out  1  datapath ALU lui
dp_alu_op1  out  XLEN  datapath ALU op1
dp_alu_op2  out  XLEN  datapath ALU op2
dp_alu_res  in  XLEN  datapath ALU result
dp_bjp_req  out  1  datapath select: BJP requester
dp_bjp_add  out  1  datapath BJP add (equals dp_bjp_req)
dp_bjp_op1  out  XLEN  datapath BJP op1
dp_bjp_op2  out  XLEN  datapath BJP op2
dp_bjp_res  in  XLEN  datapath BJP add result

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: state=IDLE, rr_ptr=0 (ALU wins first tie), all rsp_valid=0, rsp result registers=0. While state is forced to IDLE, only the combinational ready/dp terms can be nonzero.
- FSM states: IDLE, RSP.
- IDLE, arbitration:
  - One valid requester: it is granted.
  - Both valid: grant ALU if rr_ptr=0, else BJP.
- IDLE, grant cycle:
  - Granted *_req_ready=1; the other ready=0.
  - Drive dp_<granted>_req=1, its op bits, and its operands combinationally.
  - The non-granted dp_*_req, op bits and operands are 0. dp_alu_req and dp_bjp_req are never both 1.
  - Capture dp_<granted>_res into that requester's rsp_res register at the clock edge.
  - Set its rsp_valid=1, toggle rr_ptr to point away from the granted requester, and go to RSP.
- Latency: request accept to rsp_valid is exactly 1 cycle.
- ALU op sanitising: if alu_req_add and alu_req_lui are both 1, drive add only (lui forced 0). If both are 0, pass through; the datapath result is 0.
- RSP state:
  - Both req_ready=0; all dp_* outputs are 0.
  - rsp_valid and rsp_res stay stable until rsp_ready=1.
  - On handshake: clear rsp_valid and return to IDLE.
  - Base throughput: one transaction per 2 cycles.
- req_ready depends combinationally on req_valid (grant). Requesters must not make valid depend on ready.
- A requester may drop valid before acceptance without penalty; rr_ptr changes only on an accept.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Reset during RSP: rsp_valid drops immediately (asynchronously) and the pending result is discarded.

Optional Feature:
- Macro: EXU_ALU_DPATH_ARB_PIPE_EN.
- With the macro defined: in RSP, when the response handshake completes in the same cycle, the arbiter also arbitrates and accepts a new request, following IDLE rules. The dp_* outputs are driven in that cycle, and the FSM stays in RSP with the new rsp_valid. Throughput is 1 transaction per cycle. Both rsp_valid can never be 1 together.
- Without the macro: behaviour is as specified above.

Decomposition:
- Shared package:
  - FSM state encodings (IDLE=1'b0, RSP=1'b1).
  - Requester IDs (REQ_ALU=1'b0, REQ_BJP=1'b1).
  - XLEN, taken from the shared defines.
- One sub-module, exu_rr_arb2: 2-input round-robin arbiter containing the rr_ptr register, with inputs req[1:0] and adv, and output one-hot gnt[1:0].

Test Plan:
- ALU only, add, op1=0x00000005, op2=0xFFFFFFFE, datapath returns 3 -> alu_req_ready=1 in cycle 0; alu_rsp_valid=1, alu_rsp_res=0x00000003 in cycle 1; dp_bjp_req=0 throughout.
- Both valid after reset -> ALU granted first; after the ALU response handshake, BJP granted next; then a further tie is granted to ALU (alternation).
- Backpressure: hold alu_rsp_ready=0 for 4 cycles -> alu_rsp_res stays stable, both req_ready=0, all dp_* outputs=0; on release the FSM returns to IDLE.
- ALU with add=1 and lui=1 -> dp_alu_add=1, dp_alu_lui=0.
- Assert rst in RSP with bjp_rsp_valid=1 -> bjp_rsp_valid=0 before the next clock edge; state IDLE; rr_ptr=0.
- With EXU_ALU_DPATH_ARB_PIPE_EN defined, back-to-back ALU adds with rsp_ready tied high -> one result per cycle, values matching each request.

Source files
------------

// File: rtl/exu_alu_dpath_arb_pkg.sv
// exu_alu_dpath_arb_pkg: shared widths, FSM encodings and requester IDs
// for the EXU ALU datapath arbiter.
package exu_alu_dpath_arb_pkg;
    localparam int XLEN = 32;
    localparam int ALU_ADDER_WIDTH = XLEN + 1;
    localparam logic IDLE = 1'b0;
    localparam logic RSP = 1'b1;
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_BJP = 1'b1;
endpackage

// File: rtl/exu_rr_arb2.sv
// exu_rr_arb2: two-input round-robin arbiter; rr_ptr=0 favours requester 0
// on a tie and moves away from the winner whenever adv is asserted.
module exu_rr_arb2
    import exu_alu_dpath_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);
    logic rr_ptr;

    assign gnt[REQ_ALU] = req[REQ_ALU] & (~req[REQ_BJP] | ~rr_ptr);
    assign gnt[REQ_BJP] = req[REQ_BJP] & (~req[REQ_ALU] | rr_ptr);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            rr_ptr <= 1'b0;
        else if (adv)
            rr_ptr <= gnt[REQ_ALU];
endmodule

// File: rtl/exu_alu_dpath_arb.sv
// exu_alu_dpath_arb: round-robin sequencer of ALU/BJP requests onto the shared
// ALU datapath. Define EXU_ALU_DPATH_ARB_PIPE_EN to accept a request on the response handshake cycle.
module exu_alu_dpath_arb
    import exu_alu_dpath_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_req_valid,
    output logic            alu_req_ready,
    input  logic            alu_req_add,
    input  logic            alu_req_lui,
    input  logic [XLEN-1:0] alu_req_op1,
    input  logic [XLEN-1:0] alu_req_op2,
    output logic            alu_rsp_valid,
    input  logic            alu_rsp_ready,
    output logic [XLEN-1:0] alu_rsp_res,
    input  logic            bjp_req_valid,
    output logic            bjp_req_ready,
    input  logic [XLEN-1:0] bjp_req_op1,
    input  logic [XLEN-1:0] bjp_req_op2,
    output logic            bjp_rsp_valid,
    input  logic            bjp_rsp_ready,
    output logic [XLEN-1:0] bjp_rsp_res,
    output logic            dp_alu_req,
    output logic            dp_alu_add,
    output logic            dp_alu_lui,
    output logic [XLEN-1:0] dp_alu_op1,
    output logic [XLEN-1:0] dp_alu_op2,
    input  logic [XLEN-1:0] dp_alu_res,
    output logic            dp_bjp_req,
    output logic            dp_bjp_add,
    output logic [XLEN-1:0] dp_bjp_op1,
    output logic [XLEN-1:0] dp_bjp_op2,
    input  logic [XLEN-1:0] dp_bjp_res
);
    logic       state;
    logic       arb_en;
    logic       rsp_hs;
    logic [1:0] gnt;

    assign rsp_hs = (alu_rsp_valid & alu_rsp_ready) | (bjp_rsp_valid & bjp_rsp_ready);

`ifdef EXU_ALU_DPATH_ARB_PIPE_EN
    assign arb_en = (state == IDLE) | rsp_hs;
`else
    assign arb_en = (state == IDLE);
`endif

    exu_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({bjp_req_valid, alu_req_valid} & {2{arb_en}}),
        .adv (|gnt),
        .gnt (gnt)
    );

    assign alu_req_ready = gnt[REQ_ALU];
    assign bjp_req_ready = gnt[REQ_BJP];

    // add wins when both op bits are set; everything is zero unless granted
    assign dp_alu_req = gnt[REQ_ALU];
    assign dp_alu_add = gnt[REQ_ALU] & alu_req_add;
    assign dp_alu_lui = gnt[REQ_ALU] & alu_req_lui & ~alu_req_add;
    assign dp_alu_op1 = gnt[REQ_ALU] ? alu_req_op1 : '0;
    assign dp_alu_op2 = gnt[REQ_ALU] ? alu_req_op2 : '0;
    assign dp_bjp_req = gnt[REQ_BJP];
    assign dp_bjp_add = gnt[REQ_BJP];
    assign dp_bjp_op1 = gnt[REQ_BJP] ? bjp_req_op1 : '0;
    assign dp_bjp_op2 = gnt[REQ_BJP] ? bjp_req_op2 : '0;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= IDLE;
            alu_rsp_valid <= 1'b0;
            bjp_rsp_valid <= 1'b0;
            alu_rsp_res   <= '0;
            bjp_rsp_res   <= '0;
        end else if (|gnt) begin
            state         <= RSP;
            alu_rsp_valid <= gnt[REQ_ALU];
            bjp_rsp_valid <= gnt[REQ_BJP];
            if (gnt[REQ_ALU])
                alu_rsp_res <= dp_alu_res;
            if (gnt[REQ_BJP])
                bjp_rsp_res <= dp_bjp_res;
        end else if (rsp_hs) begin
            state         <= IDLE;
            alu_rsp_valid <= 1'b0;
            bjp_rsp_valid <= 1'b0;
        end
endmodule

// File: tb/tb_exu_alu_dpath_arb.sv
// tb_exu_alu_dpath_arb: directed self-checking bench for exu_alu_dpath_arb;
// define EXU_ALU_DPATH_ARB_PIPE_EN to also run the pipelined back-to-back test.
module tb_exu_alu_dpath_arb;
    import exu_alu_dpath_arb_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alu_req_valid = 1'b0, alu_req_ready, alu_req_add = 1'b0, alu_req_lui = 1'b0;
    logic [XLEN-1:0] alu_req_op1 = '0, alu_req_op2 = '0;
    logic            alu_rsp_valid, alu_rsp_ready = 1'b0;
    logic [XLEN-1:0] alu_rsp_res;
    logic            bjp_req_valid = 1'b0, bjp_req_ready;
    logic [XLEN-1:0] bjp_req_op1 = '0, bjp_req_op2 = '0;
    logic            bjp_rsp_valid, bjp_rsp_ready = 1'b0;
    logic [XLEN-1:0] bjp_rsp_res;
    logic            dp_alu_req, dp_alu_add, dp_alu_lui;
    logic [XLEN-1:0] dp_alu_op1, dp_alu_op2, dp_alu_res;
    logic            dp_bjp_req, dp_bjp_add;
    logic [XLEN-1:0] dp_bjp_op1, dp_bjp_op2, dp_bjp_res;
    int              checks = 0;
    int              failures = 0;

    always #5 clk = ~clk;

    // behavioural datapath: add, move op2, or zero
    assign dp_alu_res = dp_alu_add ? dp_alu_op1 + dp_alu_op2 : (dp_alu_lui ? dp_alu_op2 : '0);
    assign dp_bjp_res = dp_bjp_add ? dp_bjp_op1 + dp_bjp_op2 : '0;

    exu_alu_dpath_arb dut (
        .clk(clk), .rst(rst),
        .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
        .alu_req_add(alu_req_add), .alu_req_lui(alu_req_lui),
        .alu_req_op1(alu_req_op1), .alu_req_op2(alu_req_op2),
        .alu_rsp_valid(alu_rsp_valid), .alu_rsp_ready(alu_rsp_ready), .alu_rsp_res(alu_rsp_res),
        .bjp_req_valid(bjp_req_valid), .bjp_req_ready(bjp_req_ready),
        .bjp_req_op1(bjp_req_op1), .bjp_req_op2(bjp_req_op2),
        .bjp_rsp_valid(bjp_rsp_valid), .bjp_rsp_ready(bjp_rsp_ready), .bjp_rsp_res(bjp_rsp_res),
        .dp_alu_req(dp_alu_req), .dp_alu_add(dp_alu_add), .dp_alu_lui(dp_alu_lui),
        .dp_alu_op1(dp_alu_op1), .dp_alu_op2(dp_alu_op2), .dp_alu_res(dp_alu_res),
        .dp_bjp_req(dp_bjp_req), .dp_bjp_add(dp_bjp_add),
        .dp_bjp_op1(dp_bjp_op1), .dp_bjp_op2(dp_bjp_op2), .dp_bjp_res(dp_bjp_res)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        alu_rsp_ready = 1'b1;
        bjp_rsp_ready = 1'b1;
        tick();
        alu_rsp_ready = 1'b0;
        bjp_rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++; if ({alu_rsp_valid, bjp_rsp_valid} !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b want 00", {alu_rsp_valid, bjp_rsp_valid}); end
        checks++; if (alu_rsp_res !== 32'h0 || bjp_rsp_res !== 32'h0) begin failures++; $display("FAIL reset_rsp_res: got %h/%h want 0/0", alu_rsp_res, bjp_rsp_res); end
        checks++; if ({dp_alu_req, dp_bjp_req, alu_req_ready, bjp_req_ready} !== 4'b0) begin failures++; $display("FAIL reset_dp: got %b want 0000", {dp_alu_req, dp_bjp_req, alu_req_ready, bjp_req_ready}); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_alu_add;
        alu_req_valid = 1'b1; alu_req_add = 1'b1; alu_req_op1 = 32'h5; alu_req_op2 = 32'hFFFF_FFFE;
        @(negedge clk);
        checks++; if ({alu_req_ready, bjp_req_ready} !== 2'b10) begin failures++; $display("FAIL add_ready: got %b want 10", {alu_req_ready, bjp_req_ready}); end
        checks++; if ({dp_alu_req, dp_alu_add, dp_bjp_req} !== 3'b110 || dp_alu_op1 !== 32'h5 || dp_alu_op2 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL add_dp: got req/add/bjp %b op1 %h op2 %h want 110 5 fffffffe", {dp_alu_req, dp_alu_add, dp_bjp_req}, dp_alu_op1, dp_alu_op2); end
        tick();
        checks++; if (alu_rsp_valid !== 1'b1 || alu_rsp_res !== 32'h3) begin failures++; $display("FAIL add_rsp: got valid %b res %h want 1 00000003", alu_rsp_valid, alu_rsp_res); end
        @(negedge clk);
        checks++; if ({alu_req_ready, dp_alu_req, dp_bjp_req} !== 3'b000) begin failures++; $display("FAIL add_rsp_state: got %b want 000", {alu_req_ready, dp_alu_req, dp_bjp_req}); end
        alu_req_valid = 1'b0; alu_req_add = 1'b0; alu_rsp_ready = 1'b1;
        tick();
        alu_rsp_ready = 1'b0;
        checks++; if (alu_rsp_valid !== 1'b0 || alu_rsp_res !== 32'h3) begin failures++; $display("FAIL add_handshake: got valid %b res %h want 0 00000003", alu_rsp_valid, alu_rsp_res); end
    endtask

    task automatic test_round_robin;
        logic exp_alu;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_alu = (i != 1);
            alu_req_valid = 1'b1; alu_req_add = 1'b1; alu_req_op1 = 32'd1; alu_req_op2 = 32'd2;
            bjp_req_valid = 1'b1; bjp_req_op1 = 32'd10; bjp_req_op2 = 32'd20;
            @(negedge clk);
            checks++; if ({alu_req_ready, bjp_req_ready} !== {exp_alu, ~exp_alu}) begin failures++; $display("FAIL rr_grant%0d: got %b want %b", i, {alu_req_ready, bjp_req_ready}, {exp_alu, ~exp_alu}); end
            checks++; if ({dp_alu_req, dp_bjp_req, dp_bjp_add} !== {exp_alu, ~exp_alu, ~exp_alu}) begin failures++; $display("FAIL rr_dp%0d: got %b want %b", i, {dp_alu_req, dp_bjp_req, dp_bjp_add}, {exp_alu, ~exp_alu, ~exp_alu}); end
            tick();
            alu_req_valid = 1'b0; bjp_req_valid = 1'b0; alu_req_add = 1'b0;
            checks++; if ({alu_rsp_valid, bjp_rsp_valid} !== {exp_alu, ~exp_alu}) begin failures++; $display("FAIL rr_rsp_valid%0d: got %b want %b", i, {alu_rsp_valid, bjp_rsp_valid}, {exp_alu, ~exp_alu}); end
            checks++; if ((exp_alu ? alu_rsp_res : bjp_rsp_res) !== (exp_alu ? 32'd3 : 32'd30)) begin failures++; $display("FAIL rr_res%0d: got %h/%h want %0d", i, alu_rsp_res, bjp_rsp_res, exp_alu ? 3 : 30); end
            drain();
        end
    endtask

    task automatic test_backpressure;
        alu_req_valid = 1'b1; alu_req_lui = 1'b1; alu_req_op1 = 32'hFFFF; alu_req_op2 = 32'h1234_5000;
        tick();
        checks++; if (alu_rsp_valid !== 1'b1 || alu_rsp_res !== 32'h1234_5000) begin failures++; $display("FAIL bp_accept: got valid %b res %h want 1 12345000", alu_rsp_valid, alu_rsp_res); end
        bjp_req_valid = 1'b1; bjp_req_op1 = 32'h77; bjp_req_op2 = 32'h88;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({alu_req_ready, bjp_req_ready, dp_alu_req, dp_alu_add, dp_alu_lui, dp_bjp_req, dp_bjp_add} !== 7'b0 || (dp_alu_op1 | dp_alu_op2 | dp_bjp_op1 | dp_bjp_op2) !== 32'h0) begin failures++; $display("FAIL bp_idle_dp%0d: got ctl %b ops %h %h %h %h want all 0", i, {alu_req_ready, bjp_req_ready, dp_alu_req, dp_alu_add, dp_alu_lui, dp_bjp_req, dp_bjp_add}, dp_alu_op1, dp_alu_op2, dp_bjp_op1, dp_bjp_op2); end
            tick();
            checks++; if (alu_rsp_valid !== 1'b1 || alu_rsp_res !== 32'h1234_5000) begin failures++; $display("FAIL bp_hold%0d: got valid %b res %h want 1 12345000", i, alu_rsp_valid, alu_rsp_res); end
        end
        alu_req_valid = 1'b0; alu_req_lui = 1'b0; bjp_req_valid = 1'b0; alu_rsp_ready = 1'b1;
        tick();
        alu_rsp_ready = 1'b0;
        checks++; if (alu_rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got valid %b want 0", alu_rsp_valid); end
        bjp_req_valid = 1'b1; bjp_req_op1 = 32'h100; bjp_req_op2 = 32'h23;
        @(negedge clk);
        checks++; if (bjp_req_ready !== 1'b1) begin failures++; $display("FAIL bp_back_idle: got bjp_req_ready %b want 1", bjp_req_ready); end
        tick();
        bjp_req_valid = 1'b0;
        checks++; if (bjp_rsp_valid !== 1'b1 || bjp_rsp_res !== 32'h123) begin failures++; $display("FAIL bp_bjp_res: got valid %b res %h want 1 00000123", bjp_rsp_valid, bjp_rsp_res); end
        drain();
    endtask

    task automatic test_sanitize;
        alu_req_valid = 1'b1; alu_req_add = 1'b1; alu_req_lui = 1'b1; alu_req_op1 = 32'd7; alu_req_op2 = 32'd9;
        @(negedge clk);
        checks++; if ({dp_alu_add, dp_alu_lui} !== 2'b10) begin failures++; $display("FAIL san_both: got add/lui %b want 10", {dp_alu_add, dp_alu_lui}); end
        tick();
        checks++; if (alu_rsp_res !== 32'd16) begin failures++; $display("FAIL san_both_res: got %h want 00000010", alu_rsp_res); end
        alu_req_valid = 1'b0;
        drain();
        alu_req_valid = 1'b1; alu_req_add = 1'b0; alu_req_lui = 1'b0;
        @(negedge clk);
        checks++; if ({dp_alu_req, dp_alu_add, dp_alu_lui} !== 3'b100) begin failures++; $display("FAIL san_none: got req/add/lui %b want 100", {dp_alu_req, dp_alu_add, dp_alu_lui}); end
        tick();
        checks++; if (alu_rsp_valid !== 1'b1 || alu_rsp_res !== 32'h0) begin failures++; $display("FAIL san_none_res: got valid %b res %h want 1 0", alu_rsp_valid, alu_rsp_res); end
        alu_req_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_in_rsp;
        bjp_req_valid = 1'b1; bjp_req_op1 = 32'd4; bjp_req_op2 = 32'd5;
        tick();
        bjp_req_valid = 1'b0;
        checks++; if (bjp_rsp_valid !== 1'b1 || bjp_rsp_res !== 32'd9) begin failures++; $display("FAIL rrsp_pre: got valid %b res %h want 1 9", bjp_rsp_valid, bjp_rsp_res); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bjp_rsp_valid !== 1'b0 || bjp_rsp_res !== 32'h0) begin failures++; $display("FAIL rrsp_async: got valid %b res %h want 0 0", bjp_rsp_valid, bjp_rsp_res); end
        @(negedge clk);
        rst = 1'b0;
        alu_req_valid = 1'b1; alu_req_add = 1'b1; alu_req_op1 = 32'd1; alu_req_op2 = 32'd2;
        bjp_req_valid = 1'b1;
        #1;
        checks++; if ({alu_req_ready, bjp_req_ready} !== 2'b10) begin failures++; $display("FAIL rrsp_idle_ptr: got %b want 10", {alu_req_ready, bjp_req_ready}); end
        tick();
        alu_req_valid = 1'b0; bjp_req_valid = 1'b0; alu_req_add = 1'b0;
        checks++; if ({alu_rsp_valid, bjp_rsp_valid} !== 2'b10 || alu_rsp_res !== 32'd3) begin failures++; $display("FAIL rrsp_after: got valid %b res %h want 10 3", {alu_rsp_valid, bjp_rsp_valid}, alu_rsp_res); end
        drain();
    endtask

`ifdef EXU_ALU_DPATH_ARB_PIPE_EN
    task automatic test_back_to_back;
        alu_rsp_ready = 1'b1; alu_req_add = 1'b1; alu_req_op2 = 32'd100;
        for (int k = 1; k <= 4; k++) begin
            alu_req_valid = 1'b1; alu_req_op1 = k;
            @(negedge clk);
            checks++; if (alu_req_ready !== 1'b1) begin failures++; $display("FAIL pipe_ready%0d: got %b want 1", k, alu_req_ready); end
            tick();
            checks++; if ({alu_rsp_valid, bjp_rsp_valid} !== 2'b10 || alu_rsp_res !== 32'd100 + k) begin failures++; $display("FAIL pipe_res%0d: got valid %b res %0d want 10 %0d", k, {alu_rsp_valid, bjp_rsp_valid}, alu_rsp_res, 100 + k); end
        end
        alu_req_valid = 1'b0; alu_req_add = 1'b0;
        tick();
        alu_rsp_ready = 1'b0;
        checks++; if (alu_rsp_valid !== 1'b0) begin failures++; $display("FAIL pipe_drain: got valid %b want 0", alu_rsp_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_add();
        test_round_robin();
        test_backpressure();
        test_sanitize();
        test_reset_in_rsp();
`ifdef EXU_ALU_DPATH_ARB_PIPE_EN
        test_back_to_back();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
